// File: rtl/scan_pkg.sv
// -----------------------------------------------------------------------------
// scan_pkg
// Shared definitions for the multiplexed seven-segment scan controller:
//   - scan_state_t : controller FSM states (OFF, SCAN, DRAIN)
//   - NUM_DIGITS   : number of multiplexed digits
//   - DIGIT_W      : bits per digit nibble
//   - IDX_W        : width of the active-digit index
// Optional feature macro: SCAN_BLANK_EN (adds top_digit helper for
// leading-zero blanking).
// -----------------------------------------------------------------------------
package scan_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int DIGIT_W    = 4;
    localparam int IDX_W      = 3;
    localparam int VALUE_W    = NUM_DIGITS * DIGIT_W;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } scan_state_t;

`ifdef SCAN_BLANK_EN
    // Index of the most significant nonzero nibble; 0 when the value is zero
    // so that digit 0 is always shown.
    function automatic logic [IDX_W-1:0] top_digit(input logic [VALUE_W-1:0] value);
        logic [IDX_W-1:0] top_v;
        top_v = 3'd0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (value[i*DIGIT_W +: DIGIT_W] != 4'd0) begin
                top_v = i[IDX_W-1:0];
            end else begin
                top_v = top_v;
            end
        end
        return top_v;
    endfunction
`endif

endpackage

// File: rtl/scan_prescaler.sv
// -----------------------------------------------------------------------------
// scan_prescaler
// Free-running 0..DIV-1 counter producing the digit-slot tick.
// Ports:
//   clock  in   system clock
//   reset  in   asynchronous active-high reset
//   clear  in   synchronous clear; holds the count at 0 and masks tick
//   tick   out  high during the last cycle of each slot (count == DIV-1)
// -----------------------------------------------------------------------------
module scan_prescaler #(
    parameter int DIV = 100000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count_r;
    logic             last_s;

    assign last_s = (count_r == LAST);
    assign tick   = last_s & ~clear;

    // Slot counter: wraps at DIV-1, parked at zero while cleared.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear || last_s) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            count_r <= count_r + CNT_W'(1);
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
// Eight-digit multiplexed display scanner with a frame-synchronous update path.
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   en           in   display enable request
//   upd_valid    in   new display value offered
//   upd_data     in   eight nibbles, nibble i = digit i
//   upd_ready    out  update accepted this cycle when upd_valid is high
//   digit_val    out  nibble of the active digit (registered)
//   anodes       out  active-low digit enables, at most one low (registered)
//   frame_start  out  one-cycle pulse when digit 0 becomes active (registered)
// Optional feature macro: SCAN_BLANK_EN (leading-zero digit blanking).
// -----------------------------------------------------------------------------
module display_scan_ctrl
    import scan_pkg::*;
#(
    parameter int DIV = 100000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    input  logic        upd_valid,
    input  logic [31:0] upd_data,
    output logic        upd_ready,
    output logic [3:0]  digit_val,
    output logic [7:0]  anodes,
    output logic        frame_start
);

    scan_state_t        state_r, state_s;
    logic [IDX_W-1:0]   idx_r, idx_s;
    logic [VALUE_W-1:0] shown_r, shown_s;
    logic [VALUE_W-1:0] pend_r, pend_s;
    logic               pend_v_r, pend_v_s;
    logic [7:0]         anodes_r, anodes_s;
    logic [3:0]         digit_val_r, digit_val_s;
    logic               frame_start_r, frame_start_s;
    logic               tick_s, wrap_s, frame_end_s, accept_s, clear_s;

    // Prescaler is held at zero whenever the display is off.
    assign clear_s = (state_r == OFF);

    scan_prescaler #(.DIV(DIV)) u_prescaler (
        .clock (clock),
        .reset (reset),
        .clear (clear_s),
        .tick  (tick_s)
    );

    // Frame end: last slot of digit 7, or any cycle while off.
    assign wrap_s      = tick_s & (idx_r == 3'd7);
    assign frame_end_s = wrap_s | (state_r == OFF);
    assign upd_ready   = ~pend_v_r | frame_end_s;
    assign accept_s    = upd_valid & upd_ready;

    // Next state and frame_start pulse generation.
    always_comb begin
        state_s       = state_r;
        frame_start_s = 1'b0;
        case (state_r)
            OFF: begin
                if (en) begin
                    state_s       = SCAN;
                    frame_start_s = 1'b1;
                end else begin
                    state_s = OFF;
                end
            end
            SCAN: begin
                if (!en) begin
                    // A frame ending in the same cycle leaves nothing to drain.
                    state_s = wrap_s ? OFF : DRAIN;
                end else begin
                    state_s       = SCAN;
                    frame_start_s = wrap_s;
                end
            end
            DRAIN: begin
                if (en) begin
                    state_s       = SCAN;
                    frame_start_s = wrap_s;
                end else if (wrap_s) begin
                    state_s = OFF;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s = OFF;
            end
        endcase
    end

    // Digit index and update-path next values.
    always_comb begin
        idx_s    = idx_r;
        shown_s  = shown_r;
        pend_s   = pend_r;
        pend_v_s = pend_v_r;
        if (state_s == OFF) begin
            idx_s = 3'd0;
        end else if (tick_s) begin
            idx_s = idx_r + 3'd1;
        end else begin
            idx_s = idx_r;
        end
        // Pending moves to shown only at a frame boundary; a simultaneous
        // accept refills pending so pend_v stays set.
        if (frame_end_s && pend_v_r) begin
            shown_s = pend_r;
        end else begin
            shown_s = shown_r;
        end
        if (accept_s) begin
            pend_s   = upd_data;
            pend_v_s = 1'b1;
        end else if (frame_end_s) begin
            pend_v_s = 1'b0;
        end else begin
            pend_v_s = pend_v_r;
        end
    end

    // Output decode from next-cycle index/value so outputs move with the index.
    always_comb begin
        digit_val_s = shown_s[{idx_s, 2'b00} +: DIGIT_W];
        anodes_s    = 8'hFF;
        if (state_s == OFF) begin
            anodes_s = 8'hFF;
        end else begin
            anodes_s = ~(8'h01 << idx_s);
`ifdef SCAN_BLANK_EN
            if (idx_s > top_digit(shown_s)) begin
                anodes_s = 8'hFF;
            end else begin
                anodes_s = anodes_s;
            end
`endif
        end
    end

    // State, index, update-path and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r       <= OFF;
            idx_r         <= 3'd0;
            shown_r       <= 32'h0000_0000;
            pend_r        <= 32'h0000_0000;
            pend_v_r      <= 1'b0;
            anodes_r      <= 8'hFF;
            digit_val_r   <= 4'h0;
            frame_start_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            idx_r         <= idx_s;
            shown_r       <= shown_s;
            pend_r        <= pend_s;
            pend_v_r      <= pend_v_s;
            anodes_r      <= anodes_s;
            digit_val_r   <= digit_val_s;
            frame_start_r <= frame_start_s;
        end
    end

    assign anodes      = anodes_r;
    assign digit_val   = digit_val_r;
    assign frame_start = frame_start_r;

endmodule
